// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX pipeline register: lane layout,
// field offsets, lane pack/unpack helpers and the occupancy state type.
package id_ex_pkg;

    // Lane width as a function of operand and register-index widths.
    function automatic int laneWidth(input int dataW, input int regW);
        return 4 * dataW + 3 * regW;
    endfunction

    // Field offsets for arbitrary widths (LSB -> MSB order).
    function automatic int immLsb(input int dataW);
        return 0 * dataW;
    endfunction

    function automatic int rdValLsb(input int dataW);
        return 1 * dataW;
    endfunction

    function automatic int rmValLsb(input int dataW);
        return 2 * dataW;
    endfunction

    function automatic int rnValLsb(input int dataW);
        return 3 * dataW;
    endfunction

    function automatic int rdIdxLsb(input int dataW);
        return 4 * dataW;
    endfunction

    function automatic int rmIdxLsb(input int dataW, input int regW);
        return 4 * dataW + regW;
    endfunction

    function automatic int rnIdxLsb(input int dataW, input int regW);
        return 4 * dataW + 2 * regW;
    endfunction

    // Default-width layout constants.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 3;
    localparam int LANE_W     = 4 * DEF_DATA_W + 3 * DEF_REG_W;
    localparam int IMM_LSB    = 0;
    localparam int RD_VAL_LSB = DEF_DATA_W;
    localparam int RM_VAL_LSB = 2 * DEF_DATA_W;
    localparam int RN_VAL_LSB = 3 * DEF_DATA_W;
    localparam int RD_IDX_LSB = 4 * DEF_DATA_W;
    localparam int RM_IDX_LSB = 4 * DEF_DATA_W + DEF_REG_W;
    localparam int RN_IDX_LSB = 4 * DEF_DATA_W + 2 * DEF_REG_W;
    localparam int MAX_LANES  = 4;

    // Packed lane at default widths; first member is the MSB field.
    typedef struct packed {
        logic [DEF_REG_W-1:0]  rnIdx;
        logic [DEF_REG_W-1:0]  rmIdx;
        logic [DEF_REG_W-1:0]  rdIdx;
        logic [DEF_DATA_W-1:0] rnVal;
        logic [DEF_DATA_W-1:0] rmVal;
        logic [DEF_DATA_W-1:0] rdVal;
        logic [DEF_DATA_W-1:0] sextImm;
    } lane_t;

    typedef logic [MAX_LANES*LANE_W-1:0] laneBus_t;

    function automatic lane_t laneExtract(input laneBus_t bus, input int idx);
        return bus[idx*LANE_W +: LANE_W];
    endfunction

    function automatic laneBus_t laneInsert(input laneBus_t bus, input int idx,
                                            input lane_t lane);
        laneBus_t res;
        res = bus;
        res[idx*LANE_W +: LANE_W] = lane;
        return res;
    endfunction

    // Slot occupancy of the stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/id_ex_slot.sv
// One storage slot of the ID->EX stage: valid, per-lane valids, payload.
// Ports: clk, reset (sync, high), load, clear, dLaneValid, dLane,
//        valid, laneValid, lane. Load has priority over clear.
import id_ex_pkg::*;

module id_ex_slot #(
    parameter int LANES = 2,
    parameter int BUS_W = 274
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [LANES-1:0] dLaneValid,
    input  logic [BUS_W-1:0] dLane,
    output logic             valid,
    output logic [LANES-1:0] laneValid,
    output logic [BUS_W-1:0] lane
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            laneValid <= '0;
            lane      <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            laneValid <= dLaneValid;
            lane      <= dLane;
        end else if (clear) begin
            // Payload is left as-is; only the valid state is dropped.
            valid     <= 1'b0;
            laneValid <= '0;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Elastic multi-lane ID->EX register with a 2-entry skid buffer.
// Ports: clk, reset, in_valid/in_ready/in_lane_valid/in_lane (decode side),
//        flush, out_valid/out_ready/out_lane_valid/out_lane (execute side),
//        stall_cnt (saturating backpressure cycle count).
import id_ex_pkg::*;

module id_ex_pipe_reg #(
    parameter  int LANES  = 2,
    parameter  int DATA_W = 32,
    parameter  int REG_W  = 3,
    parameter  int CNT_W  = 16,
    localparam int LANE_W = laneWidth(DATA_W, REG_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*LANE_W-1:0] in_lane,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*LANE_W-1:0] out_lane,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int BUS_W = LANES * LANE_W;

    occ_e occState;
    occ_e occNext;

    logic mainLoad;
    logic mainClear;
    logic skidLoad;
    logic skidClear;
    logic fromSkid;

    logic mainValid;
    logic skidValid;
    logic [LANES-1:0] skidLaneValid;
    logic [BUS_W-1:0] skidLane;
    logic [LANES-1:0] mainDLaneValid;
    logic [BUS_W-1:0] mainDLane;

    logic accept;
    logic store;
    logic [CNT_W-1:0] stallCnt;

    // Skid occupancy alone gates the input side; out_ready never does.
    assign in_ready = !skidValid && !reset;
    assign accept   = in_valid && in_ready && !flush;
    // An all-killed bundle completes the handshake but is not stored.
    assign store    = accept && (|in_lane_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            occState <= EMPTY;
        end else begin
            occState <= occNext;
        end
    end

    always_comb begin
        occNext   = occState;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        fromSkid  = 1'b0;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
            occNext   = EMPTY;
        end else begin
            unique case (occState)
                EMPTY: begin
                    if (store) begin
                        mainLoad = 1'b1;
                        occNext  = ONE;
                    end
                end
                ONE: begin
                    if (out_ready) begin
                        if (store) begin
                            mainLoad = 1'b1;
                        end else begin
                            mainClear = 1'b1;
                            occNext   = EMPTY;
                        end
                    end else if (store) begin
                        skidLoad = 1'b1;
                        occNext  = TWO;
                    end
                end
                TWO: begin
                    // in_ready is low here, so no new bundle competes.
                    if (out_ready) begin
                        mainLoad  = 1'b1;
                        fromSkid  = 1'b1;
                        skidClear = 1'b1;
                        occNext   = ONE;
                    end
                end
                default: begin
                    occNext = EMPTY;
                end
            endcase
        end
    end

    assign mainDLaneValid = fromSkid ? skidLaneValid : in_lane_valid;
    assign mainDLane      = fromSkid ? skidLane : in_lane;

    id_ex_slot #(
        .LANES (LANES),
        .BUS_W (BUS_W)
    ) mainSlot (
        .clk        (clk),
        .reset      (reset),
        .load       (mainLoad),
        .clear      (mainClear),
        .dLaneValid (mainDLaneValid),
        .dLane      (mainDLane),
        .valid      (mainValid),
        .laneValid  (out_lane_valid),
        .lane       (out_lane)
    );

    id_ex_slot #(
        .LANES (LANES),
        .BUS_W (BUS_W)
    ) skidSlot (
        .clk        (clk),
        .reset      (reset),
        .load       (skidLoad),
        .clear      (skidClear),
        .dLaneValid (in_lane_valid),
        .dLane      (in_lane),
        .valid      (skidValid),
        .laneValid  (skidLaneValid),
        .lane       (skidLane)
    );

    assign out_valid = mainValid;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (LANES=2, CNT_W=4).
// Drives inputs 1 time unit after each rising edge and checks there.
import id_ex_pkg::*;

module tb_id_ex_pipe_reg;

    localparam int LANES = 2;
    localparam int CNT_W = 4;
    localparam int BUS_W = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_lane_valid;
    logic [BUS_W-1:0] in_lane;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_lane_valid;
    logic [BUS_W-1:0] out_lane;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    id_ex_pipe_reg #(
        .LANES  (LANES),
        .DATA_W (32),
        .REG_W  (3),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_lane        (in_lane),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_lane       (out_lane),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] mkBundle(input int k);
        lane_t l0;
        lane_t l1;
        l0 = '0;
        l1 = '0;
        l0.sextImm = 32'(k);
        l0.rdVal   = 32'h1000 + 32'(k);
        l0.rdIdx   = 3'(k);
        l1.sextImm = 32'hFFFF_FF00 + 32'(k);
        l1.rdVal   = 32'h2000 + 32'(k);
        l1.rnIdx   = 3'(k + 1);
        return {l1, l0};
    endfunction

    function automatic logic [31:0] outRd0();
        lane_t l;
        l = out_lane[LANE_W-1:0];
        return l.rdVal;
    endfunction

    function automatic logic [31:0] outRd1();
        lane_t l;
        l = out_lane[2*LANE_W-1:LANE_W];
        return l.rdVal;
    endfunction

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_lane_valid = '0;
        in_lane       = '0;
        flush         = 1'b0;
        out_ready     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_lane_valid", 64'(out_lane_valid), 64'(0));
        check("rst_lane_zero", 64'(out_lane == '0), 64'(1));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'(1));
        tick();
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_ready", 64'(in_ready), 64'(1));

        // Full-rate stream with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid      = 1'b1;
            in_lane_valid = 2'b11;
            in_lane       = mkBundle(k);
            check("stream_ready", 64'(in_ready), 64'(1));
            tick();
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_rd0", 64'(outRd0()), 64'(32'h1000 + k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", 64'(out_valid), 64'(0));
        check("stream_nostall", 64'(stall_cnt), 64'(0));

        // Backpressure: A in main, B into skid, 5 stall cycles
        in_valid = 1'b1;
        in_lane  = mkBundle(20);
        tick();
        check("bp_a_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        in_lane   = mkBundle(21);
        tick();
        check("bp_ready_drop", 64'(in_ready), 64'(0));
        check("bp_hold_a", 64'(outRd0()), 64'(32'h1014));
        check("bp_cnt1", 64'(stall_cnt), 64'(1));
        in_lane = mkBundle(22);
        repeat (4) tick();
        check("bp_cnt5", 64'(stall_cnt), 64'(5));
        check("bp_still_a", 64'(outRd0()), 64'(32'h1014));
        check("bp_still_busy", 64'(in_ready), 64'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", 64'(out_valid), 64'(1));
        check("bp_b_data", 64'(outRd0()), 64'(32'h1015));
        check("bp_b_lane1", 64'(outRd1()), 64'(32'h2015));
        check("bp_ready_back", 64'(in_ready), 64'(1));
        tick();
        check("bp_no_dup", 64'(out_valid), 64'(0));
        check("bp_cnt_hold", 64'(stall_cnt), 64'(5));

        // Killed lane and all-killed bubble
        in_valid      = 1'b1;
        in_lane_valid = 2'b10;
        in_lane       = mkBundle(30);
        tick();
        check("kill_valid", 64'(out_valid), 64'(1));
        check("kill_lv", 64'(out_lane_valid), 64'(2'b10));
        check("kill_rd1", 64'(outRd1()), 64'(32'h201E));
        in_lane_valid = 2'b00;
        in_lane       = mkBundle(31);
        tick();
        check("bubble_valid", 64'(out_valid), 64'(0));
        check("bubble_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        tick();
        check("bubble_gone", 64'(out_valid), 64'(0));

        // Flush with both slots full
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_lane_valid = 2'b11;
        in_lane       = mkBundle(40);
        tick();
        in_lane = mkBundle(41);
        tick();
        check("fl_full", 64'(in_ready), 64'(0));
        in_lane = mkBundle(42);
        flush   = 1'b1;
        tick();
        check("fl_out_valid", 64'(out_valid), 64'(0));
        check("fl_ready", 64'(in_ready), 64'(1));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_nothing", 64'(out_valid), 64'(0));

        // Flush overrides an acceptable offer
        in_valid = 1'b1;
        in_lane  = mkBundle(43);
        tick();
        check("fl2_g", 64'(outRd0()), 64'(32'h102B));
        in_lane = mkBundle(44);
        flush   = 1'b1;
        tick();
        check("fl2_drop", 64'(out_valid), 64'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl2_still_empty", 64'(out_valid), 64'(0));

        // Saturation of the 4-bit stall counter
        reset = 1'b1;
        tick();
        check("sat_rst_cnt", 64'(stall_cnt), 64'(0));
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lane   = mkBundle(50);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_cnt14", 64'(stall_cnt), 64'(14));
        end
        check("sat_cnt15", 64'(stall_cnt), 64'(15));
        check("sat_held", 64'(outRd0()), 64'(32'h1032));

        // Reset mid-stall with an offer present
        reset    = 1'b1;
        in_valid = 1'b1;
        in_lane  = mkBundle(51);
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_lv", 64'(out_lane_valid), 64'(0));
        check("mid_rst_lane", 64'(out_lane == '0), 64'(1));
        check("mid_rst_cnt", 64'(stall_cnt), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("mid_rst_noacc", 64'(out_valid), 64'(0));
        check("mid_rst_ready1", 64'(in_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
